// File: rtl/jk_bank_sched.sv
// Two-requester scheduler for a shared bank of JK flip-flops: arbitrates round-robin,
// drives one cycle of masked J/K, then checks the bank outputs against the expected result.
module jk_bank_sched #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_clr,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRIVE, ST_CHECK} state_t;

  state_t           state_q, state_d;
  logic [31:0]      init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d, jk_k_q, jk_k_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             jk_clr_q, jk_clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;

  logic             grant_valid, grant_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;

  // rr_q holds the last requester served; on contention the other one wins
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
    sel_op      = grant_id ? req1_op : req0_op;
    sel_mask    = grant_id ? req1_mask : req0_mask;
    req0_ready  = (state_q == ST_IDLE) && grant_valid && !grant_id;
    req1_ready  = (state_q == ST_IDLE) && grant_valid && grant_id;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    jk_j_d     = '0;
    jk_k_d     = '0;
    jk_clr_d   = 1'b0;
    exp_d      = exp_q;
    id_d       = id_q;
    rr_d       = rr_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_INIT: begin
        jk_clr_d = 1'b1;
        if (init_cnt_q == INIT_CYCLES - 1) begin
          state_d  = ST_IDLE;
          jk_clr_d = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_DRIVE;
          id_d    = grant_id;
          jk_j_d  = sel_mask & {WIDTH{sel_op[1]}};
          jk_k_d  = sel_mask & {WIDTH{sel_op[0]}};
          case (sel_op)
            2'b00:   exp_d = q_in;
            2'b01:   exp_d = q_in & ~sel_mask;
            2'b10:   exp_d = q_in | sel_mask;
            default: exp_d = q_in ^ sel_mask;
          endcase
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        done_id_d = id_q;
        rr_d      = id_q;
        if (q_in != exp_q) begin
          err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      jk_j_q     <= '0;
      jk_k_q     <= '0;
      jk_clr_q   <= 1'b1;
      exp_q      <= '0;
      id_q       <= 1'b0;
      rr_q       <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      jk_j_q     <= jk_j_d;
      jk_k_q     <= jk_k_d;
      jk_clr_q   <= jk_clr_d;
      exp_q      <= exp_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign jk_j    = jk_j_q;
  assign jk_k    = jk_k_q;
  assign jk_clr  = jk_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: JK bank model, transaction-level scheduler model checked every
// cycle, plus directed commands with hand-computed literal expectations.
module tb_jk_bank_sched;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [3:0] m0 = '0, m1 = '0;
  logic       r0, r1;
  logic [3:0] jk_j, jk_k, q_in;
  logic       jk_clr, busy, done, done_id, err;
  logic [7:0] err_cnt;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  checking = 1'b0;

  always #5 clk = ~clk;

  jk_bank_sched #(.WIDTH(4), .INIT_CYCLES(2)) dut (
    .clk(clk), .clear(clear),
    .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_mask(m0),
    .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_mask(m1),
    .jk_j(jk_j), .jk_k(jk_k), .jk_clr(jk_clr), .q_in(q_in),
    .busy(busy), .done(done), .done_id(done_id), .err(err), .err_cnt(err_cnt)
  );

  // External JK bank; force_q lets the bench corrupt what the controller sees
  logic [3:0] bank_q = '0;
  logic       force_q = 1'b0;
  always @(posedge clk) begin
    if (jk_clr) bank_q <= '0;
    else        bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
  end
  assign q_in = force_q ? 4'b0000 : bank_q;

  function automatic logic [3:0] apply(input logic [1:0] op, input logic [3:0] m,
                                       input logic [3:0] q);
    case (op)
      2'b00:   return q;
      2'b01:   return q & ~m;
      2'b10:   return q | m;
      default: return q ^ m;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a command accepted on edge a drives in the cycle after a,
  // and its completion is reported in the cycle after edge a+2.
  int         edge_n = 0;
  int         init_left = 0;
  bit         m_idle = 1'b0;
  bit         pend = 1'b0;
  int         acc_edge = 0;
  bit         pid = 1'b0;
  bit         m_last = 1'b1;
  int         m_errs = 0;
  logic [3:0] m_q = '0, pexp = '0, pj = '0, pk = '0;
  bit         e_done = 1'b0, e_err = 1'b0, e_did = 1'b0;

  always @(posedge clk) begin
    logic [3:0] seen;
    logic [1:0] op;
    logic [3:0] mk;
    edge_n++;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (clear) begin
      init_left = 2; m_idle = 1'b0; pend = 1'b0; m_q = '0; m_last = 1'b1; m_errs = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) m_idle = 1'b1;
    end else if (pend && edge_n == acc_edge + 2) begin
      seen   = force_q ? 4'b0000 : m_q;
      e_done = 1'b1;
      e_did  = pid;
      e_err  = (seen != pexp);
      if (e_err && m_errs < 255) m_errs++;
      m_last = pid;
      m_idle = 1'b1;
      pend   = 1'b0;
    end else if (m_idle && (v0 || v1)) begin
      pid      = (v0 && v1) ? !m_last : v1;
      op       = pid ? op1 : op0;
      mk       = pid ? m1 : m0;
      seen     = force_q ? 4'b0000 : m_q;
      pexp     = apply(op, mk, seen);
      pj       = op[1] ? mk : 4'b0000;
      pk       = op[0] ? mk : 4'b0000;
      m_q      = apply(op, mk, m_q);
      acc_edge = edge_n;
      pend     = 1'b1;
      m_idle   = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit g;
    bit drv;
    if (checking) begin
      if (clear) begin
        chk("rst_jk_j", {28'd0, jk_j}, 32'd0);
        chk("rst_jk_k", {28'd0, jk_k}, 32'd0);
        chk("rst_jk_clr", {31'd0, jk_clr}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_ready", {30'd0, r1, r0}, 32'd0);
      end else begin
        g   = (v0 && v1) ? !m_last : v1;
        drv = pend && (edge_n == acc_edge);
        chk("ready0", {31'd0, r0}, {31'd0, m_idle && (v0 || v1) && !g});
        chk("ready1", {31'd0, r1}, {31'd0, m_idle && (v0 || v1) && g});
        chk("jk_j", {28'd0, jk_j}, {28'd0, drv ? pj : 4'b0000});
        chk("jk_k", {28'd0, jk_k}, {28'd0, drv ? pk : 4'b0000});
        chk("jk_clr", {31'd0, jk_clr}, {31'd0, init_left > 0});
        chk("busy", {31'd0, busy}, {31'd0, !m_idle});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("err_cnt", {24'd0, err_cnt}, m_errs);
        if (e_done) chk("done_id", {31'd0, done_id}, {31'd0, e_did});
      end
    end
  end

  task automatic send(input bit id, input logic [1:0] op, input logic [3:0] mask,
                      input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] eq,
                      input logic ee);
    int n = 0;
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (id) begin v1 = 1'b1; op1 = op; m1 = mask; end
    else    begin v0 = 1'b1; op0 = op; m0 = mask; end
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = id ? r1 : r0;
      n++;
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: requester %0d got no ready within 20 cycles", id);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("lit_drive_j", {28'd0, jk_j}, {28'd0, ej});
    chk("lit_drive_k", {28'd0, jk_k}, {28'd0, ek});
    @(negedge clk);
    @(negedge clk);
    chk("lit_done", {31'd0, done}, 32'd1);
    chk("lit_done_id", {31'd0, done_id}, {31'd0, id});
    chk("lit_err", {31'd0, err}, {31'd0, ee});
    chk("lit_q", {28'd0, q_in}, {28'd0, eq});
  endtask

  initial begin
    int got[$];
    int n;
    bit ok;
    #1 clear = 1'b1;
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk) chk("lit_init_clr0", {31'd0, jk_clr}, 32'd1);
    @(negedge clk) chk("lit_init_clr1", {31'd0, jk_clr}, 32'd1);
    @(negedge clk);
    chk("lit_init_clr2", {31'd0, jk_clr}, 32'd0);
    chk("lit_idle_busy", {31'd0, busy}, 32'd0);
    chk("lit_idle_q", {28'd0, q_in}, 32'd0);

    send(1'b0, 2'b10, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1'b0);
    send(1'b1, 2'b11, 4'b0110, 4'b0110, 4'b0110, 4'b1100, 1'b0);

    // Contention: both requesters valid every cycle
    @(posedge clk); #1;
    v0 = 1'b1; op0 = 2'b01; m0 = 4'b1111;
    v1 = 1'b1; op1 = 2'b01; m1 = 4'b1111;
    for (int unsigned i = 0; i < 30 && got.size() < 4; i++) begin
      @(negedge clk);
      if (done) got.push_back(int'(done_id));
      if (got.size() == 4) begin v0 = 1'b0; v1 = 1'b0; end
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("lit_rr_count", got.size(), 32'd4);
    for (int unsigned i = 0; i < got.size(); i++)
      chk("lit_rr_order", got[i], i % 2);
    chk("lit_rr_q", {28'd0, q_in}, 32'd0);

    // Dropped valid in IDLE is ignored
    @(posedge clk); #1 v1 = 1'b1; op1 = 2'b10; m1 = 4'b1111;
    @(negedge clk); #1 v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_drop_q", {28'd0, q_in}, 32'd0);
    chk("lit_drop_busy", {31'd0, busy}, 32'd0);

    // Forced mismatches and saturation
    force_q = 1'b1;
    send(1'b0, 2'b10, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    chk("lit_err_cnt1", {24'd0, err_cnt}, 32'd1);
    for (int unsigned i = 0; i < 299; i++)
      send(1'b1, 2'b10, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    chk("lit_err_sat", {24'd0, err_cnt}, 32'd255);
    force_q = 1'b0;

    // Clear during DRIVE aborts the command
    @(posedge clk); #1 v0 = 1'b1; op0 = 2'b10; m0 = 4'b1111;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin @(negedge clk); ok = r0; n++; end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL abort_timeout: no ready within 20 cycles");
    end
    @(posedge clk); #1 v0 = 1'b0;
    #1 clear = 1'b1;
    #1;
    chk("lit_abort_j", {28'd0, jk_j}, 32'd0);
    chk("lit_abort_k", {28'd0, jk_k}, 32'd0);
    chk("lit_abort_clr", {31'd0, jk_clr}, 32'd1);
    chk("lit_abort_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_abort_q", {28'd0, q_in}, 32'd0);
    chk("lit_abort_busy", {31'd0, busy}, 32'd0);

    send(1'b1, 2'b10, 4'b0011, 4'b0011, 4'b0000, 4'b0011, 1'b0);
    send(1'b0, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    send(1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    send(1'b0, 2'b01, 4'b0001, 4'b0000, 4'b0001, 4'b0010, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
